arrive_depart_controller: RTL and testbench
===========================================

Name: arrive_depart_controller

Overview:
- Receiving end of the arriveSwitch/departSwitch interface driven by the bench switch stimulus.
- Synchronizes and debounces both raw switches, then turns rising edges into requests.
- Sequences a single bay through arrival and departure using timed phases.
- Emits one-cycle arriveSignal/departSignal completion pulses plus status to downstream logic and LEDs.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized switch must hold a new level before its debounced value changes (must be >=1)
ARRIVE_CYCLES, 8, cycles spent in ARRIVING (must be >=1)
DEPART_CYCLES, 8, cycles spent in DEPARTING (must be >=1)
CNT_W, 8, width of the debounce and phase counters; must hold max(DEBOUNCE_CYCLES, ARRIVE_CYCLES, DEPART_CYCLES)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  reset, synchronous, active-low (rst==0 at a posedge resets)
arriveSwitch  in  1  raw asynchronous arrive switch
departSwitch  in  1  raw asynchronous depart switch
arriveSignal  out  1  one-cycle pulse: arrival completed
departSignal  out  1  one-cycle pulse: departure completed
occupied  out  1  1 in OCCUPIED and DEPARTING
busy  out  1  1 in ARRIVING and DEPARTING
state  out  2  IDLE=00, ARRIVING=01, OCCUPIED=10, DEPARTING=11
pending  out  2  bit1 = pending arrive, bit0 = pending depart

Behaviour:
Reset (rst==0 at posedge):
- All flops clear: sync stages, debounced levels, debounce counters, phase timer, pending bits.
- state=IDLE; arriveSignal, departSignal, occupied, busy = 0; pending=00.
- Reset mid-phase aborts the phase. No completion pulse is issued.
Input path (identical per switch):
- 2-flop synchronizer q1 -> q2.
- Debounce: if q2==deb, cnt<=0. Else, if cnt==DEBOUNCE_CYCLES-1, deb<=q2 and cnt<=0; otherwise cnt<=cnt+1.
- deb_d <= deb. req = deb & ~deb_d (combinational, 1 cycle wide). Falling edges generate nothing.
- Latency: raw input first sampled high at edge N -> deb=1 after edge N+1+D -> FSM acts at edge N+2+D (D=4: edge N+6).
- A glitch shorter than D cycles at q2 produces no request.
- A switch held high through reset release counts as a new rise.
FSM (evaluated each posedge, rst==1):
- IDLE:
  - arrive_req or pending[1] -> ARRIVING; timer<=ARRIVE_CYCLES-1; clear pending[1].
  - depart_req dropped. Stale pending[0] cleared.
- ARRIVING:
  - timer!=0 -> timer-1.
  - timer==0 -> OCCUPIED. Exactly ARRIVE_CYCLES cycles are spent in ARRIVING.
  - depart_req sets pending[0]. arrive_req dropped.
- OCCUPIED:
  - depart_req or pending[0] -> DEPARTING; timer<=DEPART_CYCLES-1; clear pending[0].
  - arrive_req sets pending[1].
- DEPARTING:
  - timer!=0 -> timer-1.
  - timer==0 -> IDLE. Exactly DEPART_CYCLES cycles are spent in DEPARTING.
  - arrive_req sets pending[1]. depart_req dropped.
- Simultaneous arrive_req and depart_req:
  - IDLE: arrival taken, depart dropped.
  - OCCUPIED: departure taken, arrive latched pending.
- Pending bits are one-deep. Repeat requests while set are absorbed, not counted.
Outputs:
- All outputs registered.
- arriveSignal=1 for exactly the first cycle in OCCUPIED after ARRIVING.
- departSignal=1 for exactly the first cycle in IDLE after DEPARTING.
- arriveSignal and departSignal are never both 1.
- Pending-driven re-entry behaves identically to a fresh request: IDLE lasts 1 cycle, then ARRIVING.

Test Plan:
- Reset hold: rst=0 for 2 cycles with both switches toggling -> state=00, all outputs 0, pending=00 throughout.
- Clean arrival (D=4, A=8): arriveSwitch 0->1 sampled at edge N -> state=01 after edge N+6, state=10 after edge N+14, arriveSignal=1 for that one cycle only, occupied=1.
- Full cycle: then departSwitch 0->1 -> DEPARTING 6 edges later, IDLE 8 edges after that, departSignal single pulse, occupied=0.
- Bounce rejection: arriveSwitch high for 3 cycles, low, then high for 3 cycles -> no request, state stays 00.
- Bench switch sequence (arrive up, depart up next cycle, arrive down, depart down, all held stable for >=5 cycles each) -> arrival accepted, depart_req lands during ARRIVING and sets pending=01 -> OCCUPIED for 1 cycle then DEPARTING automatically -> IDLE with one arriveSignal and one departSignal.
- Reset mid-op: rst=0 at ARRIVING timer=3 -> next cycle state=00, no arriveSignal, pending=00; switch still high -> new arrival starts D+2 edges after release.

Source files
------------

// File: rtl/arrive_depart_controller.sv
// Single-bay arrive/depart sequencer fed by two raw switches (synchronized + debounced).
// Requests act 2+DEBOUNCE_CYCLES edges after a rise; all outputs registered.
module arrive_depart_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ARRIVE_CYCLES   = 8,
  parameter int DEPART_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveSwitch,
  input  logic       departSwitch,
  output logic       arriveSignal,
  output logic       departSignal,
  output logic       occupied,
  output logic       busy,
  output logic [1:0] state,
  output logic [1:0] pending
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARRIVING  = 2'b01,
    OCCUPIED  = 2'b10,
    DEPARTING = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEP_LAST = CNT_W'(DEPART_CYCLES - 1);

  // Index 1 = arrive, index 0 = depart, matching the pending bit order.
  logic [1:0]            sw_raw;
  logic [1:0]            sync1_q, sync2_q, deb_q, deb_dly_q;
  logic [1:0][CNT_W-1:0] deb_cnt_q;
  logic [1:0]            req_d;
  logic                  arrive_req, depart_req;

  assign sw_raw = {arriveSwitch, departSwitch};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= sw_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign req_d      = deb_q & ~deb_dly_q;
  assign arrive_req = req_d[1];
  assign depart_req = req_d[0];

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic [1:0]       pend_q;
  logic             arr_sig_q, dep_sig_q, occ_q, busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pend_q    <= '0;
      arr_sig_q <= 1'b0;
      dep_sig_q <= 1'b0;
      occ_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      arr_sig_q <= 1'b0;
      dep_sig_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A depart left over from a previous visit has nothing to act on.
          pend_q[0] <= 1'b0;
          if (arrive_req || pend_q[1]) begin
            state_q   <= ARRIVING;
            timer_q   <= ARR_LAST;
            pend_q[1] <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ARRIVING: begin
          if (depart_req) pend_q[0] <= 1'b1;
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            state_q   <= OCCUPIED;
            arr_sig_q <= 1'b1;
            occ_q     <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        OCCUPIED: begin
          if (arrive_req) pend_q[1] <= 1'b1;
          if (depart_req || pend_q[0]) begin
            state_q   <= DEPARTING;
            timer_q   <= DEP_LAST;
            pend_q[0] <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        DEPARTING: begin
          if (arrive_req) pend_q[1] <= 1'b1;
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            state_q   <= IDLE;
            dep_sig_q <= 1'b1;
            occ_q     <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arriveSignal = arr_sig_q;
  assign departSignal = dep_sig_q;
  assign occupied     = occ_q;
  assign busy         = busy_q;
  assign state        = state_q;
  assign pending      = pend_q;

endmodule

// File: tb/tb_arrive_depart_controller.sv
// Random and directed switch stimulus against a phase-level reference model of the bay.
module tb_arrive_depart_controller;

  localparam int D  = 4;
  localparam int A  = 8;
  localparam int DP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       arriveSwitch, departSwitch;
  logic       arriveSignal, departSignal, occupied, busy;
  logic [1:0] state, pending;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  arrive_depart_controller #(
    .DEBOUNCE_CYCLES(D), .ARRIVE_CYCLES(A), .DEPART_CYCLES(DP), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .arriveSwitch(arriveSwitch), .departSwitch(departSwitch),
    .arriveSignal(arriveSignal), .departSignal(departSignal),
    .occupied(occupied), .busy(busy), .state(state), .pending(pending)
  );

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase name, cycles spent in the current timed phase,
  // per-switch sample history and debounced levels. Index 1 = arrive, 0 = depart.
  int m_phase;       // 0 idle, 1 arriving, 2 occupied, 3 departing
  int m_cycles;
  bit m_pa, m_pd, m_asig, m_dsig;
  bit m_deb[2];
  bit m_deb_prev[2];
  bit rawh[2][$];
  bit q2h[2][$];

  task automatic model_step(input bit r, input bit a, input bit d);
    bit areq, dreq, q2pre, all_differ;
    bit raw[2];
    int n;
    raw[1] = a;
    raw[0] = d;
    if (!r) begin
      m_phase = 0; m_cycles = 0; m_pa = 0; m_pd = 0; m_asig = 0; m_dsig = 0;
      for (int i = 0; i < 2; i++) begin
        m_deb[i] = 0; m_deb_prev[i] = 0; rawh[i].delete(); q2h[i].delete();
      end
      return;
    end
    areq = m_deb[1] && !m_deb_prev[1];
    dreq = m_deb[0] && !m_deb_prev[0];
    m_asig = 0;
    m_dsig = 0;
    case (m_phase)
      0: begin
        m_pd = 0;
        if (areq || m_pa) begin m_phase = 1; m_cycles = 1; m_pa = 0; end
      end
      1: begin
        if (dreq) m_pd = 1;
        if (m_cycles == A) begin m_phase = 2; m_asig = 1; end
        else m_cycles++;
      end
      2: begin
        if (areq) m_pa = 1;
        if (dreq || m_pd) begin m_phase = 3; m_cycles = 1; m_pd = 0; end
      end
      default: begin
        if (areq) m_pa = 1;
        if (m_cycles == DP) begin m_phase = 0; m_dsig = 1; end
        else m_cycles++;
      end
    endcase
    // Debounced level flips once the synchronized level has disagreed with it
    // for the last D consecutive samples.
    for (int i = 0; i < 2; i++) begin
      m_deb_prev[i] = m_deb[i];
      q2pre = (rawh[i].size() >= 2) ? rawh[i][rawh[i].size()-2] : 1'b0;
      rawh[i].push_back(raw[i]);
      q2h[i].push_back(q2pre);
      n = q2h[i].size();
      if (n >= D) begin
        all_differ = 1;
        for (int k = n - D; k < n; k++)
          if (q2h[i][k] == m_deb[i]) all_differ = 0;
        if (all_differ) m_deb[i] = ~m_deb[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, arriveSwitch, departSwitch);
    @(negedge clk);
    chk("state",   int'(state),        m_phase);
    chk("pending", int'(pending),      int'({m_pa, m_pd}));
    chk("arrSig",  int'(arriveSignal), int'(m_asig));
    chk("depSig",  int'(departSignal), int'(m_dsig));
    chk("occ",     int'(occupied),     int'(m_phase >= 2));
    chk("busy",    int'(busy),         int'(m_phase == 1 || m_phase == 3));
    chk("excl",    int'(arriveSignal && departSignal), 0);
  endtask

  int a_cnt, d_cnt, waited;

  initial begin
    rst = 1'b0; arriveSwitch = 1'b0; departSwitch = 1'b0;

    // Reset hold with toggling switches
    for (int i = 0; i < 2; i++) begin
      arriveSwitch = ~arriveSwitch;
      departSwitch = (i == 0);
      tick();
      chk("rst_state", int'(state), 0);
      chk("rst_pend",  int'(pending), 0);
      chk("rst_outs",  int'({arriveSignal, departSignal, occupied, busy}), 0);
    end
    arriveSwitch = 1'b0; departSwitch = 1'b0; rst = 1'b1;
    repeat (8) tick();

    // Clean arrival: first sampled high at edge N
    arriveSwitch = 1'b1;
    tick();
    repeat (5) tick();
    chk("arr_N5", int'(state), 0);
    tick();
    chk("arr_N6", int'(state), 1);
    repeat (7) tick();
    chk("arr_N13", int'(state), 1);
    tick();
    chk("arr_N14", int'(state), 2);
    chk("arr_pulse", int'(arriveSignal), 1);
    tick();
    chk("arr_pulse_end", int'(arriveSignal), 0);
    chk("arr_occ", int'(occupied), 1);

    // Departure
    departSwitch = 1'b1;
    tick();
    repeat (5) tick();
    tick();
    chk("dep_N6", int'(state), 3);
    repeat (7) tick();
    tick();
    chk("dep_N14", int'(state), 0);
    chk("dep_pulse", int'(departSignal), 1);
    chk("dep_occ", int'(occupied), 0);
    arriveSwitch = 1'b0; departSwitch = 1'b0;
    repeat (10) tick();

    // Bounce rejection
    arriveSwitch = 1'b1; repeat (3) tick();
    arriveSwitch = 1'b0; repeat (3) tick();
    arriveSwitch = 1'b1; repeat (3) tick();
    arriveSwitch = 1'b0; repeat (12) tick();
    chk("bounce_state", int'(state), 0);

    // Arrive up, depart up next cycle, both released later
    a_cnt = 0; d_cnt = 0;
    arriveSwitch = 1'b1; tick();
    departSwitch = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); a_cnt += int'(arriveSignal); d_cnt += int'(departSignal); end
    arriveSwitch = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); a_cnt += int'(arriveSignal); d_cnt += int'(departSignal); end
    departSwitch = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); a_cnt += int'(arriveSignal); d_cnt += int'(departSignal); end
    chk("seq_arr_pulses", a_cnt, 1);
    chk("seq_dep_pulses", d_cnt, 1);
    chk("seq_idle", int'(state), 0);

    // Reset mid-arrival, switch held high through release
    arriveSwitch = 1'b1;
    waited = 0;
    while (state != 2'b01 && waited < 50) begin tick(); waited++; end
    chk("reach_arriving", int'(state), 1);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("midrst_state", int'(state), 0);
    chk("midrst_pend", int'(pending), 0);
    chk("midrst_sig", int'(arriveSignal), 0);
    rst = 1'b1;
    waited = 0;
    while (state != 2'b01 && waited < 50) begin tick(); waited++; end
    chk("rearm_latency", waited, D + 3);
    arriveSwitch = 1'b0;
    repeat (30) tick();

    // Randomized switch activity with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      arriveSwitch = ($urandom_range(0, 1) == 1);
      departSwitch = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if (!rst) begin
        tick();
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 10)) tick();
    end
    arriveSwitch = 1'b0; departSwitch = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
